counter_run_ctrl: RTL and testbench
===================================

Name: counter_run_ctrl

Overview:
- Command-driven sequencer for the lab's 8-bit enable-gated counter.
- Decides when the counter's EN is pulsed: a fixed number of counts, free-running, stopped, or cleared.
- Pulse rate is set by a programmable prescaler.
- Sits between the board/testbench command source and the counter. It keeps a shadow copy of the count so software can read progress without touching the counter.

Parameters:
- WIDTH, 8, width of the run length, the shadow count and the counter being driven.
- PRESC_W, 16, width of the prescaler reload value.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset: synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_op  in  2  00 CLEAR, 01 RUN_N, 10 FREE, 11 STOP.
- cmd_arg  in  WIDTH  number of counts for RUN_N; ignored otherwise.
- presc  in  PRESC_W  prescaler reload; latched on RUN_N/FREE acceptance.
- cnt_en  out  1  one-cycle enable pulse to the counter.
- cnt_clr  out  1  one-cycle clear pulse to the counter.
- busy  out  1  high in RUN_N or FREE.
- done  out  1  level, high in DONE state.
- run_count  out  WIDTH  shadow count = cnt_en pulses since last CLEAR/reset, modulo 2^WIDTH.

Behaviour:
- Handshake and output timing
  - A command is accepted on a rising edge where cmd_valid and cmd_ready are both high; it takes effect from the next cycle.
  - All outputs are decoded from registers only; there is no combinational input-to-output path.
- States: IDLE, CLR, RUN_N, FREE, DONE.
- Reset (rst=1 at an edge): state=IDLE, remaining=0, prescaler count pc=0, latched presc=0, run_count=0.
  - Resulting outputs: cnt_en=0, cnt_clr=0, busy=0, done=0, cmd_ready=1.
  - Reset mid-run aborts with no further cnt_en and no cnt_clr pulse.
- cmd_ready is 1 in every state except CLR.
- CLEAR, accepted in any state other than CLR:
  - next state CLR, which lasts exactly one cycle with cnt_clr=1; then IDLE.
  - run_count goes to 0 on entry to CLR.
  - Any run in progress is aborted.
- RUN_N, accepted in any state other than CLR:
  - latch presc, pc=0, remaining=cmd_arg.
  - next state RUN_N, or DONE directly if cmd_arg=0 (no pulses).
- FREE, accepted in any state other than CLR: latch presc, pc=0, next state FREE.
- STOP: next state IDLE from RUN_N/FREE/DONE; no effect in IDLE; run_count is held.
- Prescaler, active in RUN_N/FREE
  - cnt_en = (pc == latched presc).
  - On cnt_en, pc goes to 0; otherwise pc increments.
  - presc=P gives the first pulse P+1 cycles after the acceptance edge, then one pulse every P+1 cycles.
  - P=0 gives a pulse every cycle.
- Every cnt_en cycle increments run_count, wrapping 255 to 0 at WIDTH=8.
- In RUN_N, each cnt_en decrements remaining. The pulse issued with remaining=1 is the last one; next state DONE.
- DONE: done=1, busy=0, no pulses. It is held until the next accepted command.
- New command in the same cycle as a cnt_en pulse:
  - the pulse is still issued and counted (run_count and remaining update);
  - the new command then overrides the state, reloading remaining and pc.
- A new RUN_N or FREE accepted while running restarts the prescaler phase; run_count is not cleared.
- cnt_en and cnt_clr are never high in the same cycle.

Test Plan:
- Reset then CLEAR: cnt_clr high for exactly 1 cycle with cmd_ready=0 that cycle; run_count=0; back in IDLE with cmd_ready=1.
- RUN_N, arg=5, presc=0: cnt_en high for 5 consecutive cycles starting 1 cycle after acceptance; run_count=5; done=1, busy=0 from the following cycle.
- RUN_N, arg=3, presc=2: cnt_en pulses at cycles +3, +6, +9 after acceptance; then DONE with run_count=3.
- FREE, presc=0, for 260 cycles then STOP: run_count wraps and reads 4 (260 mod 256); no cnt_en after STOP takes effect; run_count is held.
- RUN_N, arg=0: DONE the next cycle with zero cnt_en pulses. Then CLEAR from DONE: cnt_clr pulse, done=0, IDLE.
- Aborts:
  - rst=1 during RUN_N, arg=10 after 4 pulses: no further cnt_en, all outputs at reset values next cycle.
  - CLEAR accepted in the same cycle as a cnt_en pulse: that pulse counts, then CLR clears run_count to 0.

Source files
------------

// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl: command-driven sequencer for an enable-gated counter.
// It issues one-cycle EN pulses at a programmable prescaled rate, either
// for a fixed number of counts or free-running, issues a one-cycle clear
// pulse on CLEAR, and keeps a shadow copy of the count.
// Every output is decoded from registered state only.
module counter_run_ctrl #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_arg,
    input  logic [PRESC_W-1:0] presc,
    output logic               cnt_en,
    output logic               cnt_clr,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   run_count
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CLR  = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_FREE = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_RUN_N = 2'b01;
    localparam logic [1:0] OP_FREE  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    logic [2:0]         state_q,     state_d;
    logic [WIDTH-1:0]   remaining_q, remaining_d;
    logic [PRESC_W-1:0] pc_q,        pc_d;
    logic [PRESC_W-1:0] presc_q,     presc_d;
    logic [WIDTH-1:0]   run_count_q, run_count_d;

    logic running;
    logic accept;

    // Output decode from registered state; no input reaches an output.
    always_comb begin
        running   = (state_q == ST_RUN) || (state_q == ST_FREE);
        cnt_en    = running && (pc_q == presc_q);
        cnt_clr   = (state_q == ST_CLR);
        busy      = running;
        done      = (state_q == ST_DONE);
        cmd_ready = (state_q != ST_CLR);
        run_count = run_count_q;
        accept    = cmd_valid && cmd_ready;
    end

    // Next-state logic: pulse bookkeeping first, then an accepted command overrides.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pc_d        = pc_q;
        presc_d     = presc_q;
        run_count_d = run_count_q;

        // Prescaler and pulse accounting while running.
        if (cnt_en) begin
            run_count_d = run_count_q + WIDTH'(1);
            pc_d        = {PRESC_W{1'b0}};
            if (state_q == ST_RUN) begin
                remaining_d = remaining_q - WIDTH'(1);
                // remaining==0 cannot occur in RUN; treated as last pulse for safety.
                if (remaining_q <= WIDTH'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end else begin
                remaining_d = remaining_q;
            end
        end else if (running) begin
            pc_d = pc_q + PRESC_W'(1);
        end else begin
            pc_d = pc_q;
        end

        // CLR lasts exactly one cycle and cannot accept commands.
        if (state_q == ST_CLR) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end

        if (accept) begin
            case (cmd_op)
                OP_CLEAR: begin
                    state_d     = ST_CLR;
                    run_count_d = {WIDTH{1'b0}};
                end
                OP_RUN_N: begin
                    presc_d     = presc;
                    pc_d        = {PRESC_W{1'b0}};
                    remaining_d = cmd_arg;
                    if (cmd_arg == {WIDTH{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                OP_FREE: begin
                    presc_d = presc;
                    pc_d    = {PRESC_W{1'b0}};
                    state_d = ST_FREE;
                end
                OP_STOP: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_d;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= {WIDTH{1'b0}};
            pc_q        <= {PRESC_W{1'b0}};
            presc_q     <= {PRESC_W{1'b0}};
            run_count_q <= {WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pc_q        <= pc_d;
            presc_q     <= presc_d;
            run_count_q <= run_count_d;
        end
    end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Testbench for counter_run_ctrl: directed scenarios followed by random
// commands, all compared every cycle against a behavioural model that
// derives pulses from elapsed cycles since the run started.
module tb_counter_run_ctrl;

    localparam int WIDTH   = 8;
    localparam int PRESC_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [WIDTH-1:0]   cmd_arg;
    logic [PRESC_W-1:0] presc;
    logic               cnt_en;
    logic               cnt_clr;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   run_count;

    counter_run_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .presc(presc),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .busy(busy), .done(done), .run_count(run_count)
    );

    always #5 clk = ~clk;

    // Model modes
    localparam int M_IDLE = 0, M_CLR = 1, M_RUN = 2, M_FREE = 3, M_DONE = 4;

    int m_mode;
    int m_p;       // latched prescaler value
    int m_since;   // cycles spent running since acceptance
    int m_rem;     // pulses left in a fixed run
    int m_count;   // pulses since clear/reset
    bit m_known = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int en_total = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare outputs for the current cycle, then advance one clock and the model.
    task automatic step();
        bit exp_en;
        bit acc;
        exp_en = ((m_mode == M_RUN) || (m_mode == M_FREE)) && ((m_since % (m_p + 1)) == m_p);
        if (m_known) begin
            check_val("cnt_en",    32'(cnt_en),    32'(exp_en));
            check_val("cnt_clr",   32'(cnt_clr),   32'(m_mode == M_CLR));
            check_val("busy",      32'(busy),      32'((m_mode == M_RUN) || (m_mode == M_FREE)));
            check_val("done",      32'(done),      32'(m_mode == M_DONE));
            check_val("cmd_ready", 32'(cmd_ready), 32'(m_mode != M_CLR));
            check_val("run_count", 32'(run_count), 32'(m_count));
            if (cnt_en === 1'b1) en_total++;
        end
        acc = cmd_valid && (m_mode != M_CLR);
        @(posedge clk);
        if (rst) begin
            m_mode = M_IDLE; m_p = 0; m_since = 0; m_rem = 0; m_count = 0;
            m_known = 1'b1;
        end else begin
            if ((m_mode == M_RUN) || (m_mode == M_FREE)) m_since++;
            if (exp_en) begin
                m_count = (m_count + 1) % 256;
                if (m_mode == M_RUN) begin
                    m_rem--;
                    if (m_rem == 0) m_mode = M_DONE;
                end
            end
            if (m_mode == M_CLR) m_mode = M_IDLE;
            if (acc) begin
                case (cmd_op)
                    2'b00: begin m_mode = M_CLR; m_count = 0; end
                    2'b01: begin
                        m_p = int'(presc); m_since = 0; m_rem = int'(cmd_arg);
                        m_mode = (cmd_arg == 0) ? M_DONE : M_RUN;
                    end
                    2'b10: begin m_p = int'(presc); m_since = 0; m_mode = M_FREE; end
                    default: if (m_mode != M_IDLE) m_mode = M_IDLE;
                endcase
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input logic [1:0] op, input int arg, input int p);
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = WIDTH'(arg); presc = PRESC_W'(p);
        step();
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_arg = WIDTH'($urandom); presc = PRESC_W'($urandom);
    endtask

    initial begin
        int e0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = '0; presc = '0;
        step();
        rst = 1'b0;
        idle(2);

        // CLEAR from reset
        issue(2'b00, 0, 0);
        check_val("clr_pulse", 32'(cnt_clr), 32'd1);
        check_val("clr_ready", 32'(cmd_ready), 32'd0);
        idle(2);

        // RUN_N 5, presc 0: five back-to-back pulses then DONE
        e0 = en_total;
        issue(2'b01, 5, 0);
        idle(7);
        check_val("run5_pulses", 32'(en_total - e0), 32'd5);
        check_val("run5_count", 32'(run_count), 32'd5);
        check_val("run5_done", 32'(done), 32'd1);

        // RUN_N 3, presc 2
        issue(2'b00, 0, 0); idle(1);
        issue(2'b01, 3, 2);
        idle(12);
        check_val("run3_count", 32'(run_count), 32'd3);

        // FREE 260 pulses then STOP: wraps to 4
        issue(2'b00, 0, 0); idle(1);
        issue(2'b10, 0, 0);
        idle(259);
        issue(2'b11, 0, 0);
        check_val("free_wrap", 32'(run_count), 32'd4);
        idle(5);
        check_val("free_held", 32'(run_count), 32'd4);

        // RUN_N 0 then CLEAR from DONE
        issue(2'b01, 0, 3);
        check_val("run0_done", 32'(done), 32'd1);
        issue(2'b00, 0, 0);
        idle(2);

        // Reset after 4 pulses of a 10-pulse run
        issue(2'b01, 10, 0);
        idle(3);
        rst = 1'b1; step(); rst = 1'b0;
        check_val("rst_abort_en", 32'(cnt_en), 32'd0);
        check_val("rst_abort_cnt", 32'(run_count), 32'd0);
        idle(3);

        // CLEAR in the same cycle as a pulse
        issue(2'b01, 6, 1);
        idle(1);
        issue(2'b00, 0, 0);
        idle(2);

        // Random phase
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            cmd_valid = ($urandom_range(0, 9) == 0);
            cmd_op = 2'($urandom);
            cmd_arg = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 2)) : WIDTH'($urandom);
            presc = ($urandom_range(0, 7) == 0) ? PRESC_W'($urandom_range(0, 40)) : PRESC_W'($urandom_range(0, 3));
            step();
        end
        rst = 1'b0; cmd_valid = 1'b0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
